fft_sram_scheduler: RTL and testbench

//  Owns the shared 256x128 coefficient/sample SRAM and sequences one FFT run around fft_top.

---
 rtl/fft_sram_scheduler.sv | 173 +++++++++++++++++
 tb/tb_fft_sram_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sram_scheduler.sv
// Shared 256xDW SRAM arbiter/sequencer: host single-word access in IDLE, FFT engine owns ports in RUN.
// Latency: host read data valid 1 cycle after grant; o_fft_working 1 cycle after accepted start.
// Backpressure: host stalls (gnt=0) outside IDLE or when start wins; optional watchdog via WATCHDOG_EN.
module fft_sram_scheduler #(
  parameter int AW        = 8,
  parameter int DW        = 128,
  parameter int WD_MARGIN = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [2:0]    i_point_config,
  input  logic [10:0]   i_cycle_count,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  input  logic          i_host_req,
  input  logic          i_host_we,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_wdata,
  output logic          o_host_gnt,
  output logic          o_host_rvalid,
  output logic [DW-1:0] o_host_rdata,
  output logic          o_fft_working,
  output logic [2:0]    o_fft_point_config,
  output logic [10:0]   o_fft_cycle_count,
  input  logic          i_fft_done,
  input  logic [AW-1:0] i_fft_raddr1,
  input  logic [AW-1:0] i_fft_raddr2,
  input  logic [AW-1:0] i_fft_waddr1,
  input  logic [AW-1:0] i_fft_waddr2,
  input  logic [DW-1:0] i_fft_wdata1,
  input  logic [DW-1:0] i_fft_wdata2,
  input  logic          i_fft_we,
  output logic [DW-1:0] o_fft_rdata1,
  output logic [DW-1:0] o_fft_rdata2,
  output logic [AW-1:0] o_sram_raddr1,
  output logic [AW-1:0] o_sram_raddr2,
  output logic [AW-1:0] o_sram_waddr1,
  output logic [AW-1:0] o_sram_waddr2,
  output logic [DW-1:0] o_sram_wdata1,
  output logic [DW-1:0] o_sram_wdata2,
  output logic          o_sram_we,
  input  logic [DW-1:0] i_sram_rdata1,
  input  logic [DW-1:0] i_sram_rdata2
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        start_acc;
  logic        wd_trip;
  logic [2:0]  cfg_q;
  logic [10:0] cnt_q;
  logic        rvalid_q;

  assign start_acc = (state == S_IDLE) && i_start && !rst;

`ifdef WATCHDOG_EN
  logic [11:0] wd_cnt;
  logic [11:0] wd_limit;
  logic [11:0] wd_cnt_inc;
  logic        error_q;

  assign wd_limit   = {1'b0, cnt_q} + 12'(WD_MARGIN);
  assign wd_cnt_inc = wd_cnt + 12'd1;
  // Fires on the RUN cycle whose ordinal equals count + margin.
  assign wd_trip    = (state == S_RUN) && !i_fft_done && (wd_cnt_inc == wd_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if (start_acc)
        wd_cnt <= '0;
      else if (state == S_RUN)
        wd_cnt <= wd_cnt_inc;
      if (start_acc)
        error_q <= 1'b0;
      else if (wd_trip)
        error_q <= 1'b1;
    end
  end

  assign o_error = error_q;
`else
  assign wd_trip = 1'b0;
  assign o_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cfg_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      rvalid_q <= o_host_gnt && !i_host_we;
      if (start_acc) begin
        cfg_q <= i_point_config;
        cnt_q <= i_cycle_count;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_RUN;
      S_RUN:   if (i_fft_done || wd_trip) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Port mux is selected by registered state only; start takes priority over a host request.
  always_comb begin
    o_host_gnt    = 1'b0;
    o_sram_raddr1 = '0;
    o_sram_raddr2 = '0;
    o_sram_waddr1 = '0;
    o_sram_waddr2 = '0;
    o_sram_wdata1 = '0;
    o_sram_wdata2 = '0;
    o_sram_we     = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (i_host_req && !i_start) begin
            o_host_gnt = 1'b1;
            if (i_host_we) begin
              o_sram_we     = 1'b1;
              o_sram_waddr1 = i_host_addr;
              o_sram_waddr2 = i_host_addr;
              o_sram_wdata1 = i_host_wdata;
              o_sram_wdata2 = i_host_wdata;
            end else begin
              o_sram_raddr1 = i_host_addr;
            end
          end
        end
        S_RUN: begin
          o_sram_raddr1 = i_fft_raddr1;
          o_sram_raddr2 = i_fft_raddr2;
          o_sram_waddr1 = i_fft_waddr1;
          o_sram_waddr2 = i_fft_waddr2;
          o_sram_wdata1 = i_fft_wdata1;
          o_sram_wdata2 = i_fft_wdata2;
          o_sram_we     = i_fft_we && !i_fft_done;
        end
        S_FLUSH: begin
          o_sram_raddr1 = i_fft_raddr1;
          o_sram_raddr2 = i_fft_raddr2;
        end
        default: ;
      endcase
    end
  end

  assign o_busy             = (state != S_IDLE);
  assign o_done             = (state == S_DONE);
  assign o_fft_working      = (state == S_RUN);
  assign o_fft_point_config = cfg_q;
  assign o_fft_cycle_count  = cnt_q;
  assign o_host_rvalid      = rvalid_q;
  assign o_host_rdata       = i_sram_rdata1;
  assign o_fft_rdata1       = i_sram_rdata1;
  assign o_fft_rdata2       = i_sram_rdata2;

endmodule

// File: tb/tb_fft_sram_scheduler.sv
// Directed bench for fft_sram_scheduler with a behavioural dual-port SRAM; watchdog scenario under WATCHDOG_EN.
module tb_fft_sram_scheduler;
  localparam int AW = 8;
  localparam int DW = 128;
  localparam logic [DW-1:0] PAT  = {16{8'hA5}};
  localparam logic [DW-1:0] PAT2 = {16{8'h3C}};

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [2:0]    i_point_config;
  logic [10:0]   i_cycle_count;
  logic          o_busy, o_done, o_error;
  logic          i_host_req, i_host_we;
  logic [AW-1:0] i_host_addr;
  logic [DW-1:0] i_host_wdata;
  logic          o_host_gnt, o_host_rvalid;
  logic [DW-1:0] o_host_rdata;
  logic          o_fft_working;
  logic [2:0]    o_fft_point_config;
  logic [10:0]   o_fft_cycle_count;
  logic          i_fft_done;
  logic [AW-1:0] i_fft_raddr1, i_fft_raddr2, i_fft_waddr1, i_fft_waddr2;
  logic [DW-1:0] i_fft_wdata1, i_fft_wdata2;
  logic          i_fft_we;
  logic [DW-1:0] o_fft_rdata1, o_fft_rdata2;
  logic [AW-1:0] o_sram_raddr1, o_sram_raddr2, o_sram_waddr1, o_sram_waddr2;
  logic [DW-1:0] o_sram_wdata1, o_sram_wdata2;
  logic          o_sram_we;
  logic [DW-1:0] i_sram_rdata1, i_sram_rdata2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (o_sram_we) begin
      mem[o_sram_waddr1] <= o_sram_wdata1;
      mem[o_sram_waddr2] <= o_sram_wdata2;
    end
    i_sram_rdata1 <= mem[o_sram_raddr1];
    i_sram_rdata2 <= mem[o_sram_raddr2];
  end

  fft_sram_scheduler #(.AW(AW), .DW(DW), .WD_MARGIN(64)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_point_config(i_point_config),
    .i_cycle_count(i_cycle_count), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt), .o_host_rvalid(o_host_rvalid),
    .o_host_rdata(o_host_rdata), .o_fft_working(o_fft_working),
    .o_fft_point_config(o_fft_point_config), .o_fft_cycle_count(o_fft_cycle_count),
    .i_fft_done(i_fft_done), .i_fft_raddr1(i_fft_raddr1), .i_fft_raddr2(i_fft_raddr2),
    .i_fft_waddr1(i_fft_waddr1), .i_fft_waddr2(i_fft_waddr2), .i_fft_wdata1(i_fft_wdata1),
    .i_fft_wdata2(i_fft_wdata2), .i_fft_we(i_fft_we), .o_fft_rdata1(o_fft_rdata1),
    .o_fft_rdata2(o_fft_rdata2), .o_sram_raddr1(o_sram_raddr1), .o_sram_raddr2(o_sram_raddr2),
    .o_sram_waddr1(o_sram_waddr1), .o_sram_waddr2(o_sram_waddr2),
    .o_sram_wdata1(o_sram_wdata1), .o_sram_wdata2(o_sram_wdata2), .o_sram_we(o_sram_we),
    .i_sram_rdata1(i_sram_rdata1), .i_sram_rdata2(i_sram_rdata2)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nxt(); nxt();
    smp();
    checks++;
    if ({o_busy, o_done, o_error, o_host_gnt, o_host_rvalid, o_fft_working, o_sram_we} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000000",
        {o_busy, o_done, o_error, o_host_gnt, o_host_rvalid, o_fft_working, o_sram_we});
    end
    checks++;
    if ({o_fft_point_config, o_fft_cycle_count, o_sram_raddr1, o_sram_waddr1} !== 30'b0) begin
      errors++; $display("FAIL reset_latched cfg=%0d cnt=%0d ra=%h wa=%h want 0",
        o_fft_point_config, o_fft_cycle_count, o_sram_raddr1, o_sram_waddr1);
    end
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_host_access();
    i_host_req = 1'b1; i_host_we = 1'b1; i_host_addr = 8'h10; i_host_wdata = PAT;
    smp();
    checks++;
    if (o_host_gnt !== 1'b1 || o_sram_we !== 1'b1) begin
      errors++; $display("FAIL host_wr_gnt gnt=%b we=%b want 1 1", o_host_gnt, o_sram_we);
    end
    checks++;
    if (o_sram_waddr1 !== 8'h10 || o_sram_waddr2 !== 8'h10 || o_sram_wdata1 !== PAT || o_sram_wdata2 !== PAT) begin
      errors++; $display("FAIL host_wr_ports wa1=%h wa2=%h wd1=%h want 10 10 %h", o_sram_waddr1, o_sram_waddr2, o_sram_wdata1, PAT);
    end
    nxt();
    i_host_we = 1'b0;
    smp();
    checks++;
    if (o_host_gnt !== 1'b1 || o_sram_raddr1 !== 8'h10 || o_sram_we !== 1'b0 || o_host_rvalid !== 1'b0) begin
      errors++; $display("FAIL host_rd_gnt gnt=%b ra=%h we=%b rv=%b want 1 10 0 0", o_host_gnt, o_sram_raddr1, o_sram_we, o_host_rvalid);
    end
    nxt();
    i_host_req = 1'b0;
    smp();
    checks++;
    if (o_host_rvalid !== 1'b1 || o_host_rdata !== PAT) begin
      errors++; $display("FAIL host_rd_data rv=%b data=%h want 1 %h", o_host_rvalid, o_host_rdata, PAT);
    end
    nxt();
    i_fft_done = 1'b1;
    smp();
    checks++;
    if (o_host_rvalid !== 1'b0) begin
      errors++; $display("FAIL host_rvalid_drop got %b want 0", o_host_rvalid);
    end
    nxt();
    i_fft_done = 1'b0;
    smp();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL idle_ignores_done busy=%b done=%b want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_run();
    nxt();
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 8'h10;
    smp();
    checks++;
    if (o_host_gnt !== 1'b1) begin
      errors++; $display("FAIL pre_start_gnt got %b want 1", o_host_gnt);
    end
    nxt();
    i_start = 1'b1; i_point_config = 3'd3; i_cycle_count = 11'd1261; i_host_addr = 8'h20;
    smp();
    checks++;
    if (o_host_gnt !== 1'b0 || o_sram_raddr1 !== 8'h00) begin
      errors++; $display("FAIL start_wins gnt=%b ra=%h want 0 00", o_host_gnt, o_sram_raddr1);
    end
    checks++;
    if (o_host_rvalid !== 1'b1 || o_host_rdata !== PAT || o_fft_working !== 1'b0) begin
      errors++; $display("FAIL rvalid_at_start rv=%b data=%h work=%b want 1 %h 0", o_host_rvalid, o_host_rdata, o_fft_working, PAT);
    end
    nxt();
    i_start = 1'b0;
    i_fft_raddr1 = 8'h33; i_fft_raddr2 = 8'h44; i_fft_waddr1 = 8'h55; i_fft_waddr2 = 8'h66;
    i_fft_wdata1 = PAT2; i_fft_wdata2 = ~PAT2; i_fft_we = 1'b1;
    smp();
    checks++;
    if (o_fft_working !== 1'b1 || o_busy !== 1'b1 || o_fft_point_config !== 3'd3 || o_fft_cycle_count !== 11'd1261) begin
      errors++; $display("FAIL run_entry work=%b busy=%b cfg=%0d cnt=%0d want 1 1 3 1261",
        o_fft_working, o_busy, o_fft_point_config, o_fft_cycle_count);
    end
    checks++;
    if (o_host_gnt !== 1'b0 || o_host_rvalid !== 1'b0 || o_error !== 1'b0) begin
      errors++; $display("FAIL run_host_stall gnt=%b rv=%b err=%b want 0 0 0", o_host_gnt, o_host_rvalid, o_error);
    end
    checks++;
    if (o_sram_raddr1 !== 8'h33 || o_sram_raddr2 !== 8'h44 || o_sram_waddr1 !== 8'h55 || o_sram_waddr2 !== 8'h66 ||
        o_sram_wdata1 !== PAT2 || o_sram_wdata2 !== ~PAT2 || o_sram_we !== 1'b1) begin
      errors++; $display("FAIL run_mux ra=%h/%h wa=%h/%h we=%b want 33/44 55/66 1",
        o_sram_raddr1, o_sram_raddr2, o_sram_waddr1, o_sram_waddr2, o_sram_we);
    end
    nxt();
    i_start = 1'b1; i_point_config = 3'd5; i_cycle_count = 11'd7; i_fft_we = 1'b0;
    nxt();
    i_start = 1'b0;
    smp();
    checks++;
    if (o_fft_working !== 1'b1 || o_fft_point_config !== 3'd3 || o_fft_cycle_count !== 11'd1261 || o_host_gnt !== 1'b0) begin
      errors++; $display("FAIL start_in_run work=%b cfg=%0d cnt=%0d gnt=%b want 1 3 1261 0",
        o_fft_working, o_fft_point_config, o_fft_cycle_count, o_host_gnt);
    end
    nxt();
    i_fft_done = 1'b1; i_fft_we = 1'b1;
    smp();
    checks++;
    if (o_sram_we !== 1'b0 || o_fft_working !== 1'b1 || o_done !== 1'b0) begin
      errors++; $display("FAIL done_cycle we=%b work=%b done=%b want 0 1 0", o_sram_we, o_fft_working, o_done);
    end
    nxt();
    i_fft_done = 1'b0;
    smp();
    checks++;
    if (o_fft_working !== 1'b0 || o_sram_we !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1 ||
        o_sram_raddr1 !== 8'h33 || o_host_gnt !== 1'b0) begin
      errors++; $display("FAIL flush work=%b we=%b done=%b busy=%b ra=%h gnt=%b want 0 0 0 1 33 0",
        o_fft_working, o_sram_we, o_done, o_busy, o_sram_raddr1, o_host_gnt);
    end
    nxt();
    i_fft_we = 1'b0;
    smp();
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b1 || o_host_gnt !== 1'b0) begin
      errors++; $display("FAIL done_pulse done=%b busy=%b gnt=%b want 1 1 0", o_done, o_busy, o_host_gnt);
    end
    nxt();
    smp();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_host_gnt !== 1'b1 || o_fft_point_config !== 3'd3) begin
      errors++; $display("FAIL back_to_idle done=%b busy=%b gnt=%b cfg=%0d want 0 0 1 3",
        o_done, o_busy, o_host_gnt, o_fft_point_config);
    end
    i_host_req = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    nxt();
    i_start = 1'b1; i_point_config = 3'd2; i_cycle_count = 11'd50;
    nxt();
    i_start = 1'b0; i_fft_we = 1'b1;
    nxt(); nxt();
    rst = 1'b1;
    nxt();
    smp();
    checks++;
    if (o_fft_working !== 1'b0 || o_sram_we !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run work=%b we=%b busy=%b want 0 0 0", o_fft_working, o_sram_we, o_busy);
    end
    for (int i = 0; i < 4; i++) nxt();
    rst = 1'b0; i_fft_we = 1'b0;
    smp();
    checks++;
    if (o_busy !== 1'b0 || o_fft_point_config !== 3'd0 || o_fft_cycle_count !== 11'd0) begin
      errors++; $display("FAIL reset_mid_run_idle busy=%b cfg=%0d cnt=%0d want 0 0 0", o_busy, o_fft_point_config, o_fft_cycle_count);
    end
  endtask

  task automatic test_long_run();
    int n;
    nxt();
    i_start = 1'b1; i_point_config = 3'd1; i_cycle_count = 11'd100;
    nxt();
    i_start = 1'b0;
    n = 0;
    smp();
    while (o_fft_working === 1'b1 && n < 400) begin
      n++;
      nxt();
      smp();
    end
`ifdef WATCHDOG_EN
    checks++;
    if (n !== 164) begin
      errors++; $display("FAIL wd_run_len got %0d run cycles want 164", n);
    end
    checks++;
    if (o_error !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
      errors++; $display("FAIL wd_flush err=%b busy=%b done=%b want 1 1 0", o_error, o_busy, o_done);
    end
    nxt();
    smp();
    checks++;
    if (o_done !== 1'b1 || o_error !== 1'b1) begin
      errors++; $display("FAIL wd_done done=%b err=%b want 1 1", o_done, o_error);
    end
    nxt();
    i_start = 1'b1; i_cycle_count = 11'd10;
    smp();
    checks++;
    if (o_error !== 1'b1) begin
      errors++; $display("FAIL wd_sticky got %b want 1", o_error);
    end
    nxt();
    i_start = 1'b0;
    smp();
    checks++;
    if (o_error !== 1'b0 || o_fft_working !== 1'b1) begin
      errors++; $display("FAIL wd_clear err=%b work=%b want 0 1", o_error, o_fft_working);
    end
`else
    checks++;
    if (n !== 400 || o_error !== 1'b0) begin
      errors++; $display("FAIL no_wd_wait run=%0d err=%b want 400 0", n, o_error);
    end
`endif
    i_fft_done = 1'b1;
    nxt();
    i_fft_done = 1'b0;
    nxt();
    smp();
    checks++;
    if (o_done !== 1'b1) begin
      errors++; $display("FAIL long_run_done got %b want 1", o_done);
    end
    nxt();
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_point_config = '0; i_cycle_count = '0;
    i_host_req = 1'b0; i_host_we = 1'b0; i_host_addr = '0; i_host_wdata = '0;
    i_fft_done = 1'b0; i_fft_raddr1 = '0; i_fft_raddr2 = '0; i_fft_waddr1 = '0; i_fft_waddr2 = '0;
    i_fft_wdata1 = '0; i_fft_wdata2 = '0; i_fft_we = 1'b0;
    test_reset();
    test_host_access();
    test_run();
    test_reset_mid_run();
    test_long_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
